wb_spi_master: RTL and testbench

- Wishbone classic slave on the SoC IO bus (wb_m2s_io_* side) that turns register writes into 8-bit SPI transfers on the spi1 pad group (ss, sck, miso, mosi).
- Sits downstream of the IO Wishbone interconnect and directly upstream of the GPIO pad mux for spi1.
- Supports CPOL/CPHA modes, a programmable clock divider, and a received-byte holding register.

---
 rtl/wb_spi_master.sv | 199 +++++++++++++++++++
 tb/tb_wb_spi_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_master.sv
// Wishbone classic slave driving an 8-bit SPI master with CPOL/CPHA modes, a clock divider and an RX holding register.
// Define SPI_RX_FIFO_EN to replace the RX holding register with a 4-entry RX FIFO.
module wb_spi_master #(
    parameter logic [15:0] DIV_RESET = 16'd3,
    parameter int          NUM_SS    = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              spi_sck_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic [NUM_SS-1:0] spi_ss_n_o,
    output logic              irq_o
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

    state_e      state_q, state_d;
    logic        ack_q;
    logic [7:0]  ctrl_q;
    logic [15:0] div_q, cnt_q;
    logic [3:0]  hp_q, sssel_q;
    logic [7:0]  tx_q, rx_q;
    logic        sck_q, mosi_q, cpha_q, overrun_q;
    logic        miso_s1_q, miso_s2_q;

    logic        req, acc, wr_en, rd_en, tx_wr, rd_rx, start, busy;
    logic        hp_end, sample_edge, done, rx_ovf, rx_valid;
    logic [2:0]  addr, rx_count;
    logic [7:0]  rx_head;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:1]};

    assign addr        = wb_adr_i[4:2];
    assign req         = wb_cyc_i & wb_stb_i & ~ack_q;
    assign acc         = ack_q & wb_cyc_i & wb_stb_i;
    assign wr_en       = acc & wb_we_i & wb_sel_i[0];
    assign rd_en       = acc & ~wb_we_i;
    assign tx_wr       = wr_en & (addr == 3'd2);
    assign rd_rx       = rd_en & (addr == 3'd3);
    assign busy        = (state_q != IDLE);
    assign start       = tx_wr & ctrl_q[0] & ~busy;
    assign hp_end      = (cnt_q >= div_q);
    assign sample_edge = cpha_q ? hp_q[0] : ~hp_q[0];
    assign done        = (state_q == DONE);

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = ack_q ? rdata : 32'h0;
    assign spi_sck_o  = busy ? sck_q : ctrl_q[1];
    assign spi_mosi_o = mosi_q;
    assign irq_o      = rx_valid & ctrl_q[3];

    always_comb begin
        rdata = '0;
        case (addr)
            3'd0:    rdata = {24'b0, ctrl_q};
            3'd1:    rdata = {16'b0, div_q};
            3'd3:    rdata = {24'b0, rx_head};
            3'd4:    rdata = {26'b0, rx_count, overrun_q, rx_valid, busy};
            default: rdata = '0;
        endcase
    end

`ifdef SPI_RX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] rd_ptr_q, wr_ptr_q;
    logic [2:0] count_q;
    logic       push, pop;

    assign push     = done & (count_q != 3'd4);
    assign pop      = rd_rx & (count_q != 3'd0);
    assign rx_ovf   = done & (count_q == 3'd4);
    assign rx_valid = (count_q != 3'd0);
    assign rx_count = count_q;
    assign rx_head  = rx_valid ? fifo_q[rd_ptr_q] : 8'h00;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rx_q;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + 3'(push) - 3'(pop);
        end
    end
`else
    logic [7:0] rxdata_q;
    logic       rx_valid_q;

    // A byte landing in the same cycle as an RXDATA read replaces it cleanly, so no overrun then.
    assign rx_ovf   = done & rx_valid_q & ~rd_rx;
    assign rx_valid = rx_valid_q;
    assign rx_count = 3'd0;
    assign rx_head  = rxdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rxdata_q   <= '0;
            rx_valid_q <= 1'b0;
        end else if (done) begin
            rxdata_q   <= rx_q;
            rx_valid_q <= 1'b1;
        end else if (rd_rx) begin
            rx_valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        spi_ss_n_o = '1;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (hp_end) state_d = SHIFT;
            SHIFT:   if (hp_end && hp_q == 4'd15) state_d = HOLD;
            HOLD:    if (hp_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (busy && !ctrl_q[0]) state_d = IDLE;
        if (state_q == SETUP || state_q == SHIFT || state_q == HOLD) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (sssel_q == 4'(i)) spi_ss_n_o[i] = 1'b0;
            end
        end
    end

    // Mode and select are latched at start so CTRL writes mid-transfer only affect the next byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_q     <= 1'b0;
            ctrl_q    <= '0;
            div_q     <= DIV_RESET;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
            hp_q      <= '0;
            sssel_q   <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cpha_q    <= 1'b0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            ack_q     <= req;
            miso_s1_q <= spi_miso_i;
            miso_s2_q <= miso_s1_q;
            if (wr_en && addr == 3'd0) ctrl_q <= wb_dat_i[7:0];
            if (wr_en && addr == 3'd1) div_q <= wb_dat_i[15:0];
            if (wr_en && addr == 3'd4 && wb_dat_i[2]) overrun_q <= 1'b0;
            if ((tx_wr && busy) || rx_ovf) overrun_q <= 1'b1;
            if (!busy) begin
                cnt_q  <= '0;
                hp_q   <= '0;
                sck_q  <= ctrl_q[1];
                mosi_q <= 1'b0;
                if (start) begin
                    cpha_q  <= ctrl_q[2];
                    sssel_q <= ctrl_q[7:4];
                    tx_q    <= ctrl_q[2] ? wb_dat_i[7:0] : {wb_dat_i[6:0], 1'b0};
                    mosi_q  <= ~ctrl_q[2] & wb_dat_i[7];
                end
            end else begin
                cnt_q <= hp_end ? 16'd0 : cnt_q + 16'd1;
                if (state_q == SHIFT && hp_end) begin
                    sck_q <= ~sck_q;
                    hp_q  <= hp_q + 4'd1;
                    if (sample_edge) begin
                        rx_q <= {rx_q[6:0], miso_s2_q};
                    end else begin
                        mosi_q <= tx_q[7];
                        tx_q   <= {tx_q[6:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_spi_master.sv
// Scoreboard bench for wb_spi_master: bus reads and SPI slave bytes are checked against queued expectations.
// Also covers the SPI_RX_FIFO_EN build when that macro is defined for both files.
module tb_wb_spi_master;
    localparam int CLK_HALF = 5;
`ifdef SPI_RX_FIFO_EN
    localparam logic [31:0] CNT1 = 32'h08;
`else
    localparam logic [31:0] CNT1 = 32'h00;
`endif

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rdExp_t;

    logic        clock, reset_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
    logic        spi_sck_o, spi_mosi_o, spi_miso_i, irq_o;
    logic [1:0]  spi_ss_n_o;

    int          checks = 0;
    int          failures = 0;
    bit          pollMode = 0;
    logic [31:0] lastRead;
    logic        tbCpha = 0;
    logic [7:0]  slaveByte = 8'h00;
    time         tRise = 0;
    time         hpTime = 0;
    rdExp_t      readQ[$];
    logic [7:0]  mosiQ[$];

    wb_spi_master #(.DIV_RESET(16'd3), .NUM_SS(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i),
        .spi_ss_n_o(spi_ss_n_o), .irq_o(irq_o)
    );

    initial clock = 1'b0;
    always #CLK_HALF clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // One Wishbone classic cycle; strobe is held through the ack cycle, which is when writes commit.
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        int n;
        wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!wb_ack_o && n < 20);
        checkOutput("wb_ack", 32'(wb_ack_o), 32'd1);
        lastRead = wb_dat_o;
        @(posedge clock); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        checkOutput("wb_ack_single", 32'(wb_ack_o), 32'd0);
    endtask

    task automatic readExpect(input string name, input logic [31:0] adr, input logic [31:0] exp);
        readQ.push_back('{name, exp});
        applyStimulus(1'b0, adr, 32'h0);
    endtask

    task automatic waitIdle();
        int n = 0;
        pollMode = 1;
        do begin
            applyStimulus(1'b0, 32'h10, 32'h0);
            n++;
        end while (lastRead[0] && n < 200);
        pollMode = 0;
        checkOutput("busy_timeout", 32'(lastRead[0]), 32'd0);
    endtask

    task automatic transfer(input logic [7:0] tx, input logic [7:0] rx);
        slaveByte = rx;
        mosiQ.push_back(tx);
        applyStimulus(1'b1, 32'h08, {24'b0, tx});
        waitIdle();
    endtask

    // Bus monitor: every read ack outside status polling consumes one expected value.
    always @(negedge clock) begin
        if (wb_ack_o && !wb_we_i && !pollMode) begin
            if (readQ.size() == 0) begin
                checks++; failures++;
                $display("[TB] FAIL unexpected_read: got 0x%0h, required no read", wb_dat_o);
            end else begin
                rdExp_t e;
                e = readQ.pop_front();
                checkOutput(e.name, wb_dat_o, e.exp);
            end
        end
    end

    // SPI slave on ss[0]: shifts slaveByte out MSB first and captures MOSI on the sample edges.
    initial begin
        logic       idleLvl;
        logic [7:0] cap, sb;
        int         nbit;
        spi_miso_i = 1'b0;
        forever begin
            @(negedge spi_ss_n_o[0]);
            idleLvl = spi_sck_o; nbit = 0; cap = 8'h0; sb = slaveByte;
            spi_miso_i = sb[7];
            while (nbit < 8) begin
                @(spi_sck_o or spi_ss_n_o[0]);
                #1;
                if (spi_ss_n_o[0]) break;
                if ((spi_sck_o != idleLvl) == (tbCpha == 1'b0)) begin
                    cap = {cap[6:0], spi_mosi_o};
                    sb = {sb[6:0], 1'b0};
                    nbit++;
                    spi_miso_i = sb[7];
                end
            end
            if (nbit == 8) begin
                if (mosiQ.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpected_mosi_byte: got 0x%0h, required none", cap);
                end else begin
                    checkOutput("mosi_byte", 32'(cap), 32'(mosiQ.pop_front()));
                end
            end
        end
    end

    always @(posedge spi_sck_o) tRise = $time;
    always @(negedge spi_sck_o) hpTime = $time - tRise;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        #12;
        checkOutput("rst_ss_n", 32'(spi_ss_n_o), 32'h3);
        checkOutput("rst_sck", 32'(spi_sck_o), 32'h0);
        checkOutput("rst_mosi", 32'(spi_mosi_o), 32'h0);
        checkOutput("rst_ack", 32'(wb_ack_o), 32'h0);
        checkOutput("rst_dat", wb_dat_o, 32'h0);
        checkOutput("rst_irq", 32'(irq_o), 32'h0);
        #11 reset_n = 1'b1;
        @(posedge clock); #1;

        readExpect("rst_ctrl", 32'h00, 32'h0);
        readExpect("rst_div", 32'h04, 32'h3);
        readExpect("rst_status", 32'h10, 32'h0);
        readExpect("rst_rxdata", 32'h0C, 32'h0);
        applyStimulus(1'b1, 32'h14, 32'hFF);
        readExpect("unmapped", 32'h14, 32'h0);
        readExpect("txdata_wo", 32'h08, 32'h0);

        // Mode 0, half-period of two clocks.
        tbCpha = 1'b0;
        applyStimulus(1'b1, 32'h00, 32'h01);
        applyStimulus(1'b1, 32'h04, 32'h01);
        slaveByte = 8'h3C;
        mosiQ.push_back(8'hA5);
        applyStimulus(1'b1, 32'h08, 32'hA5);
        readExpect("status_busy", 32'h10, 32'h1);
        waitIdle();
        checkOutput("sck_half_period", 32'(hpTime), 32'(4 * CLK_HALF));
        readExpect("status_rxv", 32'h10, 32'h2 | CNT1);
        readExpect("rx_mode0", 32'h0C, 32'h3C);
        readExpect("status_clr", 32'h10, 32'h0);

        // Mode 3: idle-high clock, sampling on rising edges.
        tbCpha = 1'b1;
        applyStimulus(1'b1, 32'h00, 32'h07);
        checkOutput("idle_sck_cpol1", 32'(spi_sck_o), 32'h1);
        transfer(8'h81, 8'hFF);
        readExpect("rx_mode3", 32'h0C, 32'hFF);

        // TXDATA write while busy is dropped and flags overrun.
        tbCpha = 1'b0;
        applyStimulus(1'b1, 32'h00, 32'h01);
        slaveByte = 8'h5A;
        mosiQ.push_back(8'h11);
        applyStimulus(1'b1, 32'h08, 32'h11);
        applyStimulus(1'b1, 32'h08, 32'h22);
        waitIdle();
        readExpect("status_ovr", 32'h10, 32'h6 | CNT1);
        applyStimulus(1'b1, 32'h10, 32'h4);
        readExpect("status_ovr_clr", 32'h10, 32'h2 | CNT1);
        readExpect("rx_ovr", 32'h0C, 32'h5A);

        // Interrupt follows rx_valid while enabled.
        applyStimulus(1'b1, 32'h00, 32'h09);
        checkOutput("irq_low", 32'(irq_o), 32'h0);
        transfer(8'hC3, 8'h77);
        checkOutput("irq_high", 32'(irq_o), 32'h1);
        readExpect("rx_irq", 32'h0C, 32'h77);
        checkOutput("irq_cleared", 32'(irq_o), 32'h0);

        // Clearing en mid-transfer aborts without delivering a byte.
        applyStimulus(1'b1, 32'h00, 32'h01);
        slaveByte = 8'h00;
        applyStimulus(1'b1, 32'h08, 32'h55);
        repeat (10) @(posedge clock);
        #1;
        applyStimulus(1'b1, 32'h00, 32'h00);
        @(posedge clock); #1;
        checkOutput("abort_ss_n", 32'(spi_ss_n_o), 32'h3);
        checkOutput("abort_sck", 32'(spi_sck_o), 32'h0);
        readExpect("abort_status", 32'h10, 32'h0);

        applyStimulus(1'b1, 32'h00, 32'h01);
`ifdef SPI_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) transfer(8'(8'h40 + i), 8'(i));
        readExpect("fifo_status_full", 32'h10, 32'h26);
        for (int i = 1; i <= 4; i++) readExpect("fifo_pop", 32'h0C, 32'(i));
        readExpect("fifo_status_empty", 32'h10, 32'h04);
`else
        transfer(8'h12, 8'h10);
        transfer(8'h34, 8'h20);
        readExpect("overwrite_status", 32'h10, 32'h6);
        readExpect("overwrite_rx", 32'h0C, 32'h20);
        readExpect("overwrite_status2", 32'h10, 32'h4);
`endif
        applyStimulus(1'b1, 32'h10, 32'h4);

        // Asynchronous reset in the middle of SHIFT.
        applyStimulus(1'b1, 32'h04, 32'h05);
        slaveByte = 8'hAA;
        applyStimulus(1'b1, 32'h08, 32'h0F);
        repeat (30) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_ss_n", 32'(spi_ss_n_o), 32'h3);
        checkOutput("midrst_sck", 32'(spi_sck_o), 32'h0);
        checkOutput("midrst_mosi", 32'(spi_mosi_o), 32'h0);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;
        readExpect("midrst_div", 32'h04, 32'h3);
        readExpect("midrst_status", 32'h10, 32'h0);
        readExpect("midrst_ctrl", 32'h00, 32'h0);

        repeat (4) @(posedge clock);
        checkOutput("readq_drained", 32'(readQ.size()), 32'd0);
        checkOutput("mosiq_drained", 32'(mosiQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
